// File: rtl/field_pkg.sv
// Shared constants, cell/colour types and the density colour map for the field render path.
// Declarations only: no state and no latency of its own.
// No flow control: every consumer runs at one pixel per pixel clock.
package field_pkg;

    localparam int unsigned CELL_SHIFT  = 4;   // 16x16-pixel cells
    localparam int unsigned FIELD_W     = 40;  // cells per field row
    localparam int unsigned FIELD_H     = 30;  // cells per field column
    localparam int unsigned FIELD_ADDRW = 11;
    localparam int unsigned FIELD_DATAW = 96;

    // One field RAM word; density is Q16.16 unsigned, velocities are not used here.
    typedef struct packed {
        logic [31:0] vy;
        logic [31:0] vx;
        logic [31:0] density;
    } cell_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    // Saturate at 1.0 (any integer part), otherwise use the top fraction nibble.
    function automatic rgb12_t density_to_rgb(input logic [31:0] dens);
        logic [3:0] lvl;
        rgb12_t     c;
        lvl = (dens[31:16] != 16'h0) ? 4'hF : dens[15:12];
        c.r = lvl;
        c.g = lvl >> 1;
        c.b = 4'hF - lvl;
        return c;
    endfunction

endpackage

// File: rtl/field_pixel_fetch_sync_delay.sv
// Reset-cleared shift register; each bit resets to its own RESET_VAL bit (lets active-low syncs idle high).
// Latency: exactly DEPTH clock cycles from din_i to dout_o (DEPTH >= 1).
// No backpressure: shifts every cycle.
module sync_delay #(
    parameter int unsigned      DEPTH     = 2,
    parameter int unsigned      WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    logic [WIDTH-1:0] pipe_q [DEPTH];

    // Shift the bundle one stage per clock; reset loads the idle pattern into every stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= RESET_VAL;
            end
        end else begin
            pipe_q[0] <= din_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign dout_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/field_pixel_fetch.sv
// Maps VGA pixels to field cells, strobes one RAM read per cell per line, colour-maps density to RGB444 (GRID_OVERLAY_EN adds a cell grid).
// Latency: in_* to out_* is exactly RAM_LAT+2 cycles; sync, de and colour stay cycle-aligned.
// No backpressure: one pixel per clock in and out; RAM_LAT must be 1..15 so data returns before the next cell.
module field_pixel_fetch
    import field_pkg::*;
#(
    parameter int unsigned RAM_LAT = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_hs,
    input  logic                   in_vs,
    input  logic                   in_de,
    input  logic [31:0]            in_col,
    input  logic [31:0]            in_row,
    output logic                   field_addr_read,
    output logic [FIELD_ADDRW-1:0] field_addr,
    input  logic [FIELD_DATAW-1:0] field_data_out,
    output logic [3:0]             out_r,
    output logic [3:0]             out_g,
    output logic [3:0]             out_b,
    output logic                   out_hs,
    output logic                   out_vs,
    output logic                   out_de
);

    // ------------------------------------------------------------------
    // Stage 0: cell coordinates and fetch decision
    // ------------------------------------------------------------------
    logic [31:0] cx_w;
    logic [31:0] cy_w;
    logic [31:0] cell_addr_full_w;
    logic        in_field_w;
    logic        col_boundary_w;
    logic        fetch_d;

    assign cx_w             = in_col >> CELL_SHIFT;
    assign cy_w             = in_row >> CELL_SHIFT;
    assign in_field_w       = (cx_w < FIELD_W) && (cy_w < FIELD_H);
    assign col_boundary_w   = (in_col[CELL_SHIFT-1:0] == '0);
    // A new cell starts at every column boundary, including col 0 after a line wrap.
    assign fetch_d          = in_de && in_field_w && col_boundary_w;
    assign cell_addr_full_w = cy_w * FIELD_W + cx_w;

`ifdef GRID_OVERLAY_EN
    logic row_boundary_w;
    logic grid_d;
    assign row_boundary_w = (in_row[CELL_SHIFT-1:0] == '0);
    assign grid_d         = (col_boundary_w || row_boundary_w) && in_field_w && in_de;
`endif

    logic                   field_addr_read_q;
    logic [FIELD_ADDRW-1:0] field_addr_q;
    logic                   s0_hs_q;
    logic                   s0_vs_q;
    logic                   s0_de_q;
    logic                   s0_inf_q;
`ifdef GRID_OVERLAY_EN
    logic                   s0_grid_q;
`endif

    // Register the read strobe/address and the per-pixel side-band; address only moves with a strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            field_addr_read_q <= 1'b0;
            field_addr_q      <= '0;
            s0_hs_q           <= 1'b1;
            s0_vs_q           <= 1'b1;
            s0_de_q           <= 1'b0;
            s0_inf_q          <= 1'b0;
`ifdef GRID_OVERLAY_EN
            s0_grid_q         <= 1'b0;
`endif
        end else begin
            field_addr_read_q <= fetch_d;
            if (fetch_d) begin
                field_addr_q <= cell_addr_full_w[FIELD_ADDRW-1:0];
            end
            s0_hs_q  <= in_hs;
            s0_vs_q  <= in_vs;
            s0_de_q  <= in_de;
            s0_inf_q <= in_field_w;
`ifdef GRID_OVERLAY_EN
            s0_grid_q <= grid_d;
`endif
        end
    end

    assign field_addr_read = field_addr_read_q;
    assign field_addr      = field_addr_q;

    // ------------------------------------------------------------------
    // Side-band delay line: covers the RAM round trip so it meets the data
    // ------------------------------------------------------------------
`ifdef GRID_OVERLAY_EN
    localparam int unsigned        DL_W   = 5;
    localparam logic [DL_W-1:0]    DL_RST = 5'b11000;
`else
    localparam int unsigned        DL_W   = 4;
    localparam logic [DL_W-1:0]    DL_RST = 4'b1100;
`endif

    logic [DL_W-1:0] dl_in_w;
    logic [DL_W-1:0] dl_out_w;
    logic            dl_hs_w;
    logic            dl_vs_w;
    logic            dl_de_w;
    logic            dl_inf_w;

`ifdef GRID_OVERLAY_EN
    logic            dl_grid_w;
    assign dl_in_w = {s0_hs_q, s0_vs_q, s0_de_q, s0_inf_q, s0_grid_q};
    assign {dl_hs_w, dl_vs_w, dl_de_w, dl_inf_w, dl_grid_w} = dl_out_w;
`else
    assign dl_in_w = {s0_hs_q, s0_vs_q, s0_de_q, s0_inf_q};
    assign {dl_hs_w, dl_vs_w, dl_de_w, dl_inf_w} = dl_out_w;
`endif

    sync_delay #(
        .DEPTH     (RAM_LAT),
        .WIDTH     (DL_W),
        .RESET_VAL (DL_RST)
    ) u_side_dly (
        .clk     (clk),
        .reset_n (reset_n),
        .din_i   (dl_in_w),
        .dout_o  (dl_out_w)
    );

    // ------------------------------------------------------------------
    // Capture: fetch flag emerges in the cycle the RAM data is valid
    // ------------------------------------------------------------------
    logic  cap_vld_w;
    cell_t cell_w;
    logic [31:0] dens_q;
    logic [31:0] dens_src_w;

    sync_delay #(
        .DEPTH     (RAM_LAT),
        .WIDTH     (1),
        .RESET_VAL (1'b0)
    ) u_fetch_dly (
        .clk     (clk),
        .reset_n (reset_n),
        .din_i   (field_addr_read_q),
        .dout_o  (cap_vld_w)
    );

    assign cell_w = field_data_out;
    // Bypass the fresh word so the first pixel of a cell already uses it.
    assign dens_src_w = cap_vld_w ? cell_w.density : dens_q;

    // Hold the cell density for the remaining pixels of the cell.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dens_q <= '0;
        end else if (cap_vld_w) begin
            dens_q <= cell_w.density;
        end
    end

    // ------------------------------------------------------------------
    // Colour map and output register
    // ------------------------------------------------------------------
    rgb12_t rgb_d;
    rgb12_t out_rgb_q;
    logic   out_hs_q;
    logic   out_vs_q;
    logic   out_de_q;

    // Black outside the visible field; overlay (when built) wins over the map.
    always_comb begin
        rgb_d = '0;
        if (dl_de_w && dl_inf_w) begin
            rgb_d = density_to_rgb(dens_src_w);
        end
`ifdef GRID_OVERLAY_EN
        if (dl_grid_w) begin
            rgb_d = 12'h444;
        end
`endif
    end

    // Final register stage: colour and syncs leave together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_rgb_q <= '0;
            out_hs_q  <= 1'b1;
            out_vs_q  <= 1'b1;
            out_de_q  <= 1'b0;
        end else begin
            out_rgb_q <= rgb_d;
            out_hs_q  <= dl_hs_w;
            out_vs_q  <= dl_vs_w;
            out_de_q  <= dl_de_w;
        end
    end

    assign out_r  = out_rgb_q.r;
    assign out_g  = out_rgb_q.g;
    assign out_b  = out_rgb_q.b;
    assign out_hs = out_hs_q;
    assign out_vs = out_vs_q;
    assign out_de = out_de_q;

    // Velocities and the high address bits are intentionally dropped.
    logic unused_w;
    assign unused_w = ^{cell_w.vy, cell_w.vx, cell_addr_full_w[31:FIELD_ADDRW]};

endmodule

// File: tb/tb_field_pixel_fetch.sv
// Directed bench for field_pixel_fetch with a RAM_LAT-deep field RAM model.
// Latency: each pixel is checked for its strobe one cycle later and its colour/sync RAM_LAT+2 cycles later.
// No backpressure: one pixel is driven per clock.
module tb_field_pixel_fetch;
    import field_pkg::*;

    localparam int RAM_LAT = 2;

`ifdef GRID_OVERLAY_EN
    localparam bit OV = 1'b1;
`else
    localparam bit OV = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic                   in_hs, in_vs, in_de;
    logic [31:0]            in_col, in_row;
    logic                   field_addr_read;
    logic [FIELD_ADDRW-1:0] field_addr;
    logic [FIELD_DATAW-1:0] field_data_out;
    logic [3:0]             out_r, out_g, out_b;
    logic                   out_hs, out_vs, out_de;

    int n_cmp = 0;
    int n_bad = 0;

    always #20 clk = ~clk;

    field_pixel_fetch #(.RAM_LAT(RAM_LAT)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .in_hs           (in_hs),
        .in_vs           (in_vs),
        .in_de           (in_de),
        .in_col          (in_col),
        .in_row          (in_row),
        .field_addr_read (field_addr_read),
        .field_addr      (field_addr),
        .field_data_out  (field_data_out),
        .out_r           (out_r),
        .out_g           (out_g),
        .out_b           (out_b),
        .out_hs          (out_hs),
        .out_vs          (out_vs),
        .out_de          (out_de)
    );

    // Field RAM contents (density word only; velocities are filler).
    function automatic logic [31:0] ram_dens(input logic [FIELD_ADDRW-1:0] a);
        case (a)
            11'd0:    return 32'h0001_0000;
            11'd1:    return 32'h0000_8000;
            11'd13:   return 32'h0000_A000;
            11'd40:   return 32'h0000_3000;
            11'd1199: return 32'h0002_1234;
            default:  return 32'h0000_5000;
        endcase
    endfunction

    logic [FIELD_DATAW-1:0] ram_pipe [RAM_LAT];
    always @(posedge clk) begin
        ram_pipe[0] <= {32'hDEAD_BEEF, 32'hCAFE_F00D, ram_dens(field_addr)};
        for (int i = 1; i < RAM_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
    end
    assign field_data_out = ram_pipe[RAM_LAT-1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] ov(input int col, input int row, input logic [11:0] m);
        return (OV && ((col % 16 == 0) || (row % 16 == 0))) ? 12'h444 : m;
    endfunction

    // Expected outputs of the pixels still inside the pipeline; [3] is the one now at the outputs.
    logic [11:0] q_rgb [4];
    logic        q_hs  [4];
    logic        q_vs  [4];
    logic        q_de  [4];
    logic        q_chk [4];

    task automatic q_flush();
        for (int i = 0; i < 4; i++) begin
            q_rgb[i] = 12'h000; q_hs[i] = 1'b1; q_vs[i] = 1'b1; q_de[i] = 1'b0; q_chk[i] = 1'b1;
        end
    endtask

    // Drive one pixel, clock it, check its strobe and the colour/sync of the pixel 3 slots earlier.
    task automatic pix(input logic de, input int col, input int row, input logic hs, input logic vs,
                       input logic stb, input int addr, input logic vis, input logic [11:0] map,
                       input logic rchk);
        logic exp_stb;
        in_de = de; in_col = col; in_row = row; in_hs = hs; in_vs = vs;
        for (int i = 3; i > 0; i--) begin
            q_rgb[i] = q_rgb[i-1]; q_hs[i] = q_hs[i-1]; q_vs[i] = q_vs[i-1];
            q_de[i] = q_de[i-1]; q_chk[i] = q_chk[i-1];
        end
        if (reset_n) begin
            q_rgb[0] = vis ? ov(col, row, map) : 12'h000;
            q_hs[0] = hs; q_vs[0] = vs; q_de[0] = de; q_chk[0] = rchk;
            exp_stb = stb;
        end else begin
            q_rgb[0] = 12'h000; q_hs[0] = 1'b1; q_vs[0] = 1'b1; q_de[0] = 1'b0; q_chk[0] = 1'b1;
            exp_stb = 1'b0;
        end
        @(posedge clk); #1;
        chk($sformatf("strobe c%0d r%0d", col, row), {31'd0, field_addr_read}, {31'd0, exp_stb});
        if (exp_stb && field_addr_read)
            chk($sformatf("addr c%0d r%0d", col, row), {21'd0, field_addr}, addr);
        if (q_chk[3])
            chk($sformatf("rgb after c%0d r%0d", col, row), {20'd0, out_r, out_g, out_b}, {20'd0, q_rgb[3]});
        chk("out_hs", {31'd0, out_hs}, {31'd0, q_hs[3]});
        chk("out_vs", {31'd0, out_vs}, {31'd0, q_vs[3]});
        chk("out_de", {31'd0, out_de}, {31'd0, q_de[3]});
    endtask

    initial begin
        reset_n = 1'b0; in_hs = 1'b1; in_vs = 1'b1; in_de = 1'b0; in_col = 0; in_row = 0;
        q_flush();

        // Reset held with toggling stimulus: everything stays idle.
        for (int i = 0; i < 6; i++)
            pix(i[0], i * 16, 0, i[1], i[2], 1'b0, 0, 1'b1, 12'hF70, 1'b1);

        reset_n = 1'b1;
        for (int i = 0; i < 4; i++)
            pix(1'b0, 700, 0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 12'h000, 1'b1);

        // Row 0: cells 0 (F70), 1 (847), 2 (52A); one strobe per cell.
        for (int c = 0; c < 36; c++)
            pix(1'b1, c, 0, 1'b1, 1'b1, (c % 16 == 0), c / 16, 1'b1,
                (c < 16) ? 12'hF70 : (c < 32) ? 12'h847 : 12'h52A, 1'b1);

        // Blanking with toggling syncs: no strobes, black, syncs delayed.
        for (int c = 640; c < 652; c++)
            pix(1'b0, c, 0, c[1], c[2], 1'b0, 0, 1'b0, 12'h000, 1'b1);
        for (int c = 0; c < 8; c++)
            pix(1'b0, c, 1, c[0], ~c[1], 1'b0, 0, 1'b0, 12'h000, 1'b1);
        // de high but right of the field: no strobe, black, de passes through.
        for (int c = 640; c < 656; c++)
            pix(1'b1, c, 0, c[0], c[1], 1'b0, 0, 1'b0, 12'h000, 1'b1);

        // Address corners: row 16 -> 40, last cell -> 1199, frame wrap -> 0.
        for (int c = 0; c < 4; c++)
            pix(1'b1, c, 16, 1'b1, 1'b1, (c == 0), 40, 1'b1, 12'h31C, 1'b1);
        for (int c = 624; c < 628; c++)
            pix(1'b1, c, 479, 1'b1, 1'b1, (c == 624), 1199, 1'b1, 12'hF70, 1'b1);
        for (int c = 0; c < 2; c++)
            pix(1'b1, c, 0, 1'b1, 1'b0, (c == 0), 0, 1'b1, 12'hF70, 1'b1);

        // Grid candidates: col 32 and row 48 (overlay only when built in).
        for (int c = 32; c < 36; c++)
            pix(1'b1, c, 50, 1'b1, 1'b1, (c == 32), 122, 1'b1, 12'h52A, 1'b1);
        for (int c = 32; c < 36; c++)
            pix(1'b1, c, 48, 1'b1, 1'b1, (c == 32), 122, 1'b1, 12'h52A, 1'b1);

        // Reset pulse mid-line at col 200.
        for (int c = 192; c < 200; c++)
            pix(1'b1, c, 5, 1'b1, 1'b1, (c == 192), 12, 1'b1, 12'h52A, 1'b1);
        in_de = 1'b1; in_col = 200; in_row = 5; in_hs = 1'b1; in_vs = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("rst rgb", {20'd0, out_r, out_g, out_b}, 32'h0);
        chk("rst hs", {31'd0, out_hs}, 32'h1);
        chk("rst vs", {31'd0, out_vs}, 32'h1);
        chk("rst de", {31'd0, out_de}, 32'h0);
        chk("rst strobe", {31'd0, field_addr_read}, 32'h0);
        q_flush();
        @(posedge clk); #1;
        for (int c = 201; c < 204; c++)
            pix(1'b1, c, 5, 1'b1, 1'b1, 1'b0, 0, 1'b1, 12'h52A, 1'b1);
        reset_n = 1'b1;
        for (int c = 204; c < 216; c++)
            pix(1'b1, c, 5, 1'b1, 1'b1, (c == 208), 13, 1'b1,
                (c < 208) ? 12'h00F : 12'hA55, (c >= 208));

        // Drain.
        for (int i = 0; i < 4; i++)
            pix(1'b0, 700, 6, 1'b1, 1'b1, 1'b0, 0, 1'b0, 12'h000, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
